// File: rtl/mem_write_buffer.sv
// Posted-write FIFO between the ALU memory-write port and the data-memory bus.
// Queues up to depth {addr, data} writes and drains them in order over valid/ready.
module mem_write_buffer #(
  parameter int mem_addr_width = 16,
  parameter int data_width     = 32,
  parameter int depth          = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       w_valid_i,
  input  logic [mem_addr_width-1:0]  w_addr_i,
  input  logic [data_width-1:0]      w_write_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(depth):0]     count_o,
  output logic                       overflow_o,
  output logic                       m_valid_o,
  output logic [mem_addr_width-1:0]  m_addr_o,
  output logic [data_width-1:0]      m_data_o,
  input  logic                       m_ready_i
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth);

  // Memory handshake: an entry transfers on any rising edge where m_valid_o
  // and m_ready_i are both high; m_valid_o never depends on m_ready_i, and
  // m_addr_o/m_data_o hold steady while m_valid_o is high and m_ready_i low.

  logic [mem_addr_width-1:0] addr_mem [depth];
  logic [data_width-1:0]     data_mem [depth];
  logic [ptr_w-1:0]          wp, rp;
  logic [cnt_w-1:0]          count;
  logic                      overflow;
  logic                      pop, push, drop;

  assign pop  = (count != '0) && m_ready_i;
  // A full buffer still accepts a write in the cycle it drains the head.
  assign push = w_valid_i && ((count != depth_c) || pop);
  assign drop = w_valid_i && (count == depth_c) && !pop;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is not reset; only the pointers decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wp] <= w_addr_i;
      data_mem[wp] <= w_write_i;
    end
  end

  assign count_o    = count;
  assign full_o     = (count == depth_c);
  assign empty_o    = (count == '0);
  assign m_valid_o  = (count != '0);
  assign overflow_o = overflow;
  assign m_addr_o   = addr_mem[rp];
  assign m_data_o   = data_mem[rp];

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer: directed scenarios plus random
// push/ready traffic compared against a queue-based reference model.
module tb_mem_write_buffer;

  localparam int aw = 16;
  localparam int dw = 32;
  localparam int dp = 4;
  localparam int ew = aw + dw;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic            w_valid_i;
  logic [aw-1:0]   w_addr_i;
  logic [dw-1:0]   w_write_i;
  logic            full_o, empty_o, overflow_o, m_valid_o, m_ready_i;
  logic [$clog2(dp):0] count_o;
  logic [aw-1:0]   m_addr_o;
  logic [dw-1:0]   m_data_o;

  mem_write_buffer #(.mem_addr_width(aw), .data_width(dw), .depth(dp)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .w_valid_i  (w_valid_i),
    .w_addr_i   (w_addr_i),
    .w_write_i  (w_write_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .m_valid_o  (m_valid_o),
    .m_addr_o   (m_addr_o),
    .m_data_o   (m_data_o),
    .m_ready_i  (m_ready_i)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // scoreboard state
  logic [ew-1:0] exp_q[$];
  logic          model_ovf;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            max_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_outputs();
    logic [ew-1:0] head;
    check("m_valid", 64'(m_valid_o), 64'(exp_q.size() != 0));
    check("count",   64'(count_o),   64'(exp_q.size()));
    check("full",    64'(full_o),    64'(exp_q.size() == dp));
    check("empty",   64'(empty_o),   64'(exp_q.size() == 0));
    check("ovf",     64'(overflow_o), 64'(model_ovf));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("head_addr", 64'(m_addr_o), 64'(head[ew-1:dw]));
      check("head_data", 64'(m_data_o), 64'(head[dw-1:0]));
    end
  endtask

  // driver: called at a negedge; checks current outputs, applies inputs
  // across one rising edge, updates the model, returns at the next negedge
  task automatic step(input logic v, input logic [aw-1:0] a, input logic [dw-1:0] d,
                      input logic r);
    w_valid_i = v;
    w_addr_i  = a;
    w_write_i = d;
    m_ready_i = r;
    check_outputs();
    @(posedge clk_i);
    if (r && exp_q.size() != 0) void'(exp_q.pop_front());
    if (v) begin
      if (exp_q.size() < dp) exp_q.push_back({a, d});
      else model_ovf = 1'b1;
    end
    if (exp_q.size() > max_cnt) max_cnt = exp_q.size();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    w_valid_i = 1'b0;
    m_ready_i = 1'b0;
    w_addr_i  = '0;
    w_write_i = '0;
    reset_ni  = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  initial begin
    reset_ni  = 1'b1;
    w_valid_i = 1'b0;
    m_ready_i = 1'b0;
    w_addr_i  = '0;
    w_write_i = '0;
    model_ovf = 1'b0;
    @(negedge clk_i);
    do_reset();

    // reset state
    check("rst_full",  64'(full_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(m_valid_o), 64'd0);
    check("rst_ovf",   64'(overflow_o), 64'd0);

    // single write, held under back-pressure
    step(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0);
    check("t1_valid", 64'(m_valid_o), 64'd1);
    check("t1_addr",  64'(m_addr_o), 64'h0010);
    check("t1_data",  64'(m_data_o), 64'hDEADBEEF);
    check("t1_count", 64'(count_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0000, 32'h0, 1'b0);
      check("t1_hold_addr", 64'(m_addr_o), 64'h0010);
      check("t1_hold_data", 64'(m_data_o), 64'hDEADBEEF);
    end
    step(1'b0, 16'h0000, 32'h0, 1'b1);
    check("t1_empty", 64'(empty_o), 64'd1);

    // fill, drop, drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 32'(i * 32'h11), 1'b0);
    check("t2_full",  64'(full_o), 64'd1);
    check("t2_count", 64'(count_o), 64'd4);
    step(1'b1, 16'd5, 32'h55, 1'b0);
    check("t2_ovf",   64'(overflow_o), 64'd1);
    check("t2_count_after_drop", 64'(count_o), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      check("t2_drain_addr", 64'(m_addr_o), 64'(i));
      step(1'b0, 16'h0, 32'h0, 1'b1);
    end
    check("t2_empty", 64'(empty_o), 64'd1);

    // push into full buffer while draining
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 32'(i * 32'h11), 1'b0);
    check("t3_head", 64'(m_addr_o), 64'd1);
    step(1'b1, 16'd9, 32'h99, 1'b1);
    check("t3_count", 64'(count_o), 64'd4);
    check("t3_ovf",   64'(overflow_o), 64'd0);
    check("t3_head2", 64'(m_addr_o), 64'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 32'h0, 1'b1);
    check("t3_empty", 64'(empty_o), 64'd1);

    // stream 10 writes with memory always ready
    do_reset();
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(16'h100 + i), 32'($urandom), 1'b1);
      check("t4_follow", 64'(m_addr_o), 64'(16'h100 + i));
      check("t4_cnt_le1", 64'(count_o <= 1), 64'd1);
    end
    step(1'b0, 16'h0, 32'h0, 1'b1);
    check("t4_max_cnt", 64'(max_cnt), 64'd1);
    check("t4_empty", 64'(empty_o), 64'd1);

    // asynchronous reset mid-drain
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h200 + i), 32'(i), 1'b0);
    step(1'b1, 16'h2FF, 32'hFF, 1'b0);
    check("t5_ovf_pre", 64'(overflow_o), 64'd1);
    step(1'b0, 16'h0, 32'h0, 1'b1);
    check("t5_count_pre", 64'(count_o), 64'd3);
    m_ready_i = 1'b1;
    @(posedge clk_i);
    #2;
    reset_ni = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    #1;
    check("t5_rst_valid", 64'(m_valid_o), 64'd0);
    check("t5_rst_count", 64'(count_o), 64'd0);
    check("t5_rst_ovf",   64'(overflow_o), 64'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    step(1'b1, 16'h0ABC, 32'h12345678, 1'b0);
    check("t5_addr", 64'(m_addr_o), 64'h0ABC);
    check("t5_data", 64'(m_data_o), 64'h12345678);
    step(1'b0, 16'h0, 32'h0, 1'b1);

    // random traffic against the reference queue
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      logic v, r;
      if (i == 6000) do_reset();
      if ((i / 1000) % 2 == 0) begin
        v = ($urandom_range(0, 99) < 60);
        r = ($urandom_range(0, 99) < 50);
      end else begin
        v = ($urandom_range(0, 99) < 85);
        r = ($urandom_range(0, 99) < 30);
      end
      step(v, 16'($urandom), 32'($urandom), r);
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Posted-write FIFO between the ALU's memory-write port and the data-memory bus. It accepts one write (address + data) per cycle from the ALU and queues up to `depth` writes. It drains them in order to memory over a valid/ready handshake, so that memory back-pressure never loses a write. It reports full/empty status for future pipeline stalling and flags any write dropped while full.

## Interface
- `mem_addr_width`, 16, width of a memory address; matches the ALU write address.
- `data_width`, 32, width of a write datum; equals the register width.
- `depth`, 4, number of queued entries; must be a power of two and at least 2.

- `clk_i`  in  1  sole clock; all state changes on its rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset. Asserting it clears all state immediately; deassertion is synchronised externally.
- `w_valid_i`  in  1  ALU write request; each cycle it is high is one distinct write.
- `w_addr_i`  in  `mem_addr_width`  write address; sampled when `w_valid_i` is high.
- `w_write_i`  in  `data_width`  write data; sampled when `w_valid_i` is high.
- `full_o`  out  1  high when `count == depth`.
- `empty_o`  out  1  high when `count == 0`.
- `count_o`  out  `$clog2(depth)+1`  number of queued entries.
- `overflow_o`  out  1  sticky; set when a write is dropped.
- `m_valid_o`  out  1  memory-side request valid; equals `!empty_o`.
- `m_addr_o`  out  `mem_addr_width`  head-entry address.
- `m_data_o`  out  `data_width`  head-entry data.
- `m_ready_i`  in  1  memory accepts the head entry this cycle.

## Operation
- Storage is a circular buffer of `depth` entries, each holding {addr, data}.
  - Write pointer `wp` and read pointer `rp` are each `$clog2(depth)` bits and wrap naturally from `depth-1` to 0.
  - A separate counter holds `count`, ranging 0..`depth`.
- Pop: occurs when `m_valid_o && m_ready_i`. `rp` increments.
- Push: occurs when `w_valid_i && (count < depth || pop)`. The entry is written at `wp` and `wp` increments.
  - A full buffer therefore accepts a write in the same cycle that it drains one.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Drop: occurs when `w_valid_i && count == depth && !pop`.
  - The write is discarded; no pointer or storage changes.
  - `overflow_o` is set and stays high until reset.
- `m_addr_o`/`m_data_o` are driven from the storage entry at `rp`.
  - While `m_valid_o && !m_ready_i`, they must stay stable cycle to cycle, since a push never overwrites the entry at `rp` in that case.
  - While `empty_o`, their value is don't-care; the implementation drives the stale entry.
- Ordering: memory sees writes in exact acceptance order. There is no coalescing or reordering, including for writes to the same address.
- `m_ready_i` while `m_valid_o` is low is ignored.
- Reset (asynchronous, any time, including mid-drain):
  - `wp`, `rp` and `count` clear to 0.
  - `overflow_o` clears to 0.
  - Queued entries are discarded.
  - Storage contents need not be cleared.

## Timing
- Reset values: `full_o`=0, `empty_o`=1, `count_o`=0, `overflow_o`=0, `m_valid_o`=0.
  - `m_addr_o`/`m_data_o` read storage entry 0, whose contents are don't-care after reset.
- Status outputs (`full_o`, `empty_o`, `count_o`, `m_valid_o`) are registered and reflect state after the previous edge.
- Fill latency: a push into an empty buffer at edge N raises `m_valid_o` after edge N, with `m_addr_o`/`m_data_o` showing the pushed write. There is no combinational path from `w_*` to `m_*`.
- Drain throughput: one write per cycle while `m_ready_i` is held high and the buffer is non-empty.
- Sustained throughput: simultaneous push and pop sustains one write per cycle at any occupancy, including full.
- Overflow: `overflow_o` rises after the edge at which the drop occurs.
- Pointer wrap: after `depth` pushes, `wp` returns to 0; FIFO order is preserved across the wrap.

## Test plan
- Reset, then push (0x0010, 0xDEADBEEF) with `m_ready_i`=0.
  - Next cycle: `m_valid_o`=1, `m_addr_o`=0x0010, `m_data_o`=0xDEADBEEF, `count_o`=1.
  - Outputs stay stable for 5 cycles; raising `m_ready_i` for one cycle then gives `empty_o`=1.
- Push addr 1..4 (data = addr×0x11) with `m_ready_i`=0.
  - `full_o`=1, `count_o`=4.
  - A fifth push (addr 5) is dropped and `overflow_o`=1.
  - Draining yields exactly addr 1, 2, 3, 4 in order.
- Fill to 4, then push addr 9 with `m_ready_i`=1 in the same cycle.
  - Head addr 1 pops, addr 9 is accepted, `count_o` stays 4, `overflow_o` stays 0.
  - Addr 9 drains last.
- Stream 10 writes at one per cycle with `m_ready_i`=1 throughout.
  - `count_o` never exceeds 1.
  - All 10 appear on `m_*` in order, each exactly one cycle after its push, across the pointer wrap.
- Queue 3 entries with `overflow_o`=1, then pulse `reset_ni` low mid-cycle while `m_ready_i`=1.
  - Immediately: `m_valid_o`=0, `count_o`=0, `overflow_o`=0.
  - After release, one push appears at the head with the correct address and data.
- Random push/ready traffic over 10k cycles checked against a reference queue model.
  - No write is lost unless `overflow_o` rises, and no write is duplicated.
